timing_menu_controller: RTL

TIMING_MENU_CONTROLLER -- requirements
Module: timing_menu_controller

---
 rtl/timing_menu_controller.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/timing_menu_controller.sv
// timing_menu_controller
//   Button-driven menu for editing the three traffic-light timing values.
//   Four raw buttons are synchronized, debounced and edge-detected. A
//   three-state FSM (IDLE / BROWSE / EDIT) then lets the user pick an item,
//   edit a shadow copy, and commit it to the timing outputs.
//
// Ports
//   clk             in   system clock, rising edge
//   rst             in   synchronous active-high reset
//   btn_c/u/d/l     in   raw asynchronous buttons (enter, up, down, back)
//   green_duration  out  committed green time in seconds   (5..99)
//   yellow_duration out  committed yellow time in seconds  (1..9)
//   red_holding     out  committed red hold time in seconds (1..9)
//   menu_active     out  high in BROWSE or EDIT
//   edit_active     out  high in EDIT
//   menu_item       out  selected item: 0=green, 1=yellow, 2=red
//   display_value   out  shadow in EDIT, committed value in BROWSE, 0 in IDLE
//   config_updated  out  one-cycle pulse when a value is committed
module timing_menu_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned TIMEOUT_CYCLES  = 1_000_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_c,
    input  logic       btn_u,
    input  logic       btn_d,
    input  logic       btn_l,
    output logic [7:0] green_duration,
    output logic [7:0] yellow_duration,
    output logic [7:0] red_holding,
    output logic       menu_active,
    output logic       edit_active,
    output logic [1:0] menu_item,
    output logic [7:0] display_value,
    output logic       config_updated
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, BROWSE, EDIT} state_t;

    // Button index: 0=c, 1=u, 2=d, 3=l
    logic [3:0]      raw;
    logic [3:0]      sync1, sync2, level, level_d;
    logic [DB_W-1:0] db_cnt [4];
    logic [3:0]      press;

    assign raw   = {btn_l, btn_d, btn_u, btn_c};
    assign press = level & ~level_d;

    // Synchronizer and debouncer: the count tracks consecutive cycles in
    // which the synchronized level disagrees with the accepted level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_d <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] != level[i]) begin
                    if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        level[i]  <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    function automatic logic [7:0] lim_min(input logic [1:0] item);
        return (item == 2'd0) ? 8'd5 : 8'd1;
    endfunction

    function automatic logic [7:0] lim_max(input logic [1:0] item);
        return (item == 2'd0) ? 8'd99 : 8'd9;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [1:0] item);
        return (v >= lim_max(item)) ? lim_max(item) : v + 8'd1;
    endfunction

    function automatic logic [7:0] sat_dec(input logic [7:0] v, input logic [1:0] item);
        return (v <= lim_min(item)) ? lim_min(item) : v - 8'd1;
    endfunction

    function automatic logic [7:0] pick(input logic [1:0] item, input logic [7:0] g,
                                        input logic [7:0] y, input logic [7:0] r);
        case (item)
            2'd0:    return g;
            2'd1:    return y;
            default: return r;
        endcase
    endfunction

    state_t          state, state_n;
    logic [1:0]      item_n;
    logic [7:0]      shadow, shadow_n;
    logic [7:0]      green_n, yellow_n, red_n, display_n;
    logic            cfg_n;
    logic [TO_W-1:0] tcnt, tcnt_n;
    logic            ev_l, ev_c, ev_u, ev_d;

    // Fixed priority: back > enter > up > down; losers are dropped.
    assign ev_l = press[3];
    assign ev_c = press[0] & ~press[3];
    assign ev_u = press[1] & ~press[3] & ~press[0];
    assign ev_d = press[2] & ~press[3] & ~press[0] & ~press[1];

    always_comb begin
        state_n  = state;
        item_n   = menu_item;
        shadow_n = shadow;
        green_n  = green_duration;
        yellow_n = yellow_duration;
        red_n    = red_holding;
        cfg_n    = 1'b0;
        tcnt_n   = tcnt + 1'b1;

        case (state)
            IDLE: begin
                tcnt_n = '0;
                if (ev_c) begin
                    state_n = BROWSE;
                    item_n  = 2'd0;
                end
            end
            BROWSE: begin
                if (ev_l) begin
                    state_n = IDLE;
                end else if (ev_c) begin
                    state_n  = EDIT;
                    shadow_n = pick(menu_item, green_duration, yellow_duration, red_holding);
                end else if (ev_u) begin
                    item_n = (menu_item == 2'd0) ? 2'd2 : menu_item - 2'd1;
                end else if (ev_d) begin
                    item_n = (menu_item == 2'd2) ? 2'd0 : menu_item + 2'd1;
                end
            end
            EDIT: begin
                if (ev_l) begin
                    state_n  = BROWSE;
                    shadow_n = 8'd0;
                end else if (ev_c) begin
                    state_n = BROWSE;
                    cfg_n   = 1'b1;
                    case (menu_item)
                        2'd0:    green_n  = shadow;
                        2'd1:    yellow_n = shadow;
                        default: red_n    = shadow;
                    endcase
                end else if (ev_u) begin
                    shadow_n = sat_inc(shadow, menu_item);
                end else if (ev_d) begin
                    shadow_n = sat_dec(shadow, menu_item);
                end
            end
            default: state_n = IDLE;
        endcase

        // Inactivity exit; any event in the same cycle takes precedence.
        if (state == BROWSE || state == EDIT) begin
            if (|press) begin
                tcnt_n = '0;
            end else if (tcnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                state_n  = IDLE;
                shadow_n = 8'd0;
                tcnt_n   = '0;
            end
        end

        case (state_n)
            EDIT:    display_n = shadow_n;
            BROWSE:  display_n = pick(item_n, green_n, yellow_n, red_n);
            default: display_n = 8'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            menu_item       <= 2'd0;
            shadow          <= 8'd0;
            green_duration  <= 8'd10;
            yellow_duration <= 8'd3;
            red_holding     <= 8'd2;
            display_value   <= 8'd0;
            menu_active     <= 1'b0;
            edit_active     <= 1'b0;
            config_updated  <= 1'b0;
            tcnt            <= '0;
        end else begin
            state           <= state_n;
            menu_item       <= item_n;
            shadow          <= shadow_n;
            green_duration  <= green_n;
            yellow_duration <= yellow_n;
            red_holding     <= red_n;
            display_value   <= display_n;
            menu_active     <= (state_n != IDLE);
            edit_active     <= (state_n == EDIT);
            config_updated  <= cfg_n;
            tcnt            <= tcnt_n;
        end
    end

endmodule
